// File: rtl/rv64g_vlsu_batch_seq_if.sv
// Dcache VLSU request/response bundle between the batch sequencer (master)
// and rv64g_l1_dcache (slave).
interface rv64g_vlsu_batch_seq_if #(
    parameter int NUM_LANES = 8
);
    logic                      vlsu_req_o;
    logic [NUM_LANES-1:0]      vlsu_lane_valid_o;
    logic [NUM_LANES-1:0]      vlsu_lane_we_o;
    logic [NUM_LANES*64-1:0]   vlsu_lane_addr_o;
    logic [NUM_LANES*64-1:0]   vlsu_lane_wdata_o;
    logic [NUM_LANES*8-1:0]    vlsu_lane_be_o;
    logic                      vlsu_ready_i;
    logic                      vlsu_done_i;
    logic [NUM_LANES*64-1:0]   vlsu_lane_rdata_i;

    modport master (
        output vlsu_req_o, vlsu_lane_valid_o, vlsu_lane_we_o,
               vlsu_lane_addr_o, vlsu_lane_wdata_o, vlsu_lane_be_o,
        input  vlsu_ready_i, vlsu_done_i, vlsu_lane_rdata_i
    );

    modport slave (
        input  vlsu_req_o, vlsu_lane_valid_o, vlsu_lane_we_o,
               vlsu_lane_addr_o, vlsu_lane_wdata_o, vlsu_lane_be_o,
        output vlsu_ready_i, vlsu_done_i, vlsu_lane_rdata_i
    );
endinterface

// File: rtl/rv64g_vlsu_batch_seq.sv
// Vector load/store batch sequencer: splits one strided vector memory command
// into NUM_LANES-element batches for the dcache VLSU port and returns aligned,
// zero-extended load data per batch.
// Optional: define VLSU_PERF_CNT_EN to add perf_batches_o / perf_stall_o.
module rv64g_vlsu_batch_seq #(
    parameter int NUM_LANES = 8,
    parameter int VL_W      = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [63:0]             cmd_base_i,
    input  logic [63:0]             cmd_stride_i,
    input  logic [VL_W-1:0]         cmd_vl_i,
    input  logic [1:0]              cmd_eew_i,
    output logic                    cmd_done_o,
    output logic                    cmd_err_o,
    input  logic                    st_data_valid_i,
    output logic                    st_data_ready_o,
    input  logic [NUM_LANES*64-1:0] st_data_i,
    output logic                    ld_valid_o,
    output logic [VL_W-1:0]         ld_batch_o,
    output logic [NUM_LANES-1:0]    ld_mask_o,
    output logic [NUM_LANES*64-1:0] ld_data_o,
    rv64g_vlsu_batch_seq_if.master  vlsu
`ifdef VLSU_PERF_CNT_EN
    ,
    output logic [31:0]             perf_batches_o,
    output logic [31:0]             perf_stall_o
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]              state;
    logic                    we_q;
    logic [63:0]             stride_q;
    logic [VL_W-1:0]         vl_q;
    logic [1:0]              eew_q;
    logic [VL_W-1:0]         batch_q;
    logic [63:0]             bbase_q;
    logic [NUM_LANES*64-1:0] st_buf_q;
    logic [NUM_LANES*64-1:0] rdata_q;
    logic                    idle_done_q;
    logic                    err_q;

    logic [3:0]              eew_bytes;
    logic [63:0]             elem_mask;
    logic [NUM_LANES-1:0]    lane_valid;
    logic [NUM_LANES*64-1:0] lane_addr;
    logic [NUM_LANES*64-1:0] lane_wdata;
    logic [NUM_LANES*8-1:0]  lane_be;
    logic [NUM_LANES*64-1:0] lane_ld;
    logic                    last_batch;
    logic                    active;
    logic [3:0]              align_mask;
    logic                    misaligned;

    // Per-lane address, byte enable, positioned write data and aligned load data
    always_comb begin
        logic [63:0] addr;
        logic [31:0] elem;
        logic [5:0]  shamt;
        logic [15:0] be16;
        eew_bytes  = 4'(1) << eew_q;
        elem_mask  = (eew_q == 2'd3) ? '1 : ((64'(1) << {eew_bytes, 3'b000}) - 64'(1));
        lane_valid = '0;
        lane_addr  = '0;
        lane_wdata = '0;
        lane_be    = '0;
        lane_ld    = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            elem  = 32'(batch_q) * 32'(NUM_LANES) + 32'(k);
            addr  = bbase_q + 64'(k) * stride_q;
            shamt = {addr[2:0], 3'b000};
            be16  = ((16'(1) << eew_bytes) - 16'(1)) << addr[2:0];
            lane_ld[k*64 +: 64] = (rdata_q[k*64 +: 64] >> shamt) & elem_mask;
            if (elem < 32'(vl_q)) begin
                lane_valid[k]          = 1'b1;
                lane_addr[k*64 +: 64]  = addr;
                lane_be[k*8 +: 8]      = be16[7:0];
                lane_wdata[k*64 +: 64] = (st_buf_q[k*64 +: 64] & elem_mask) << shamt;
            end
        end
        last_batch = (32'(batch_q) + 32'd1) * 32'(NUM_LANES) >= 32'(vl_q);
        align_mask = (4'(1) << cmd_eew_i) - 4'(1);
        misaligned = |((cmd_base_i[3:0] | cmd_stride_i[3:0]) & align_mask);
    end

    // Output decode from state; payload only driven while a request is open
    always_comb begin
        active            = (state == S_ISSUE) || (state == S_WAIT);
        cmd_ready_o       = (state == S_IDLE);
        st_data_ready_o   = (state == S_FETCH);
        cmd_done_o        = idle_done_q || ((state == S_RESP) && last_batch);
        cmd_err_o         = err_q;
        vlsu.vlsu_req_o        = active;
        vlsu.vlsu_lane_valid_o = active ? lane_valid : '0;
        vlsu.vlsu_lane_we_o    = (active && we_q) ? lane_valid : '0;
        vlsu.vlsu_lane_addr_o  = active ? lane_addr : '0;
        vlsu.vlsu_lane_wdata_o = active ? lane_wdata : '0;
        vlsu.vlsu_lane_be_o    = active ? lane_be : '0;
        ld_valid_o        = (state == S_RESP) && !we_q;
        ld_batch_o        = ld_valid_o ? batch_q : '0;
        ld_mask_o         = ld_valid_o ? lane_valid : '0;
        ld_data_o         = ld_valid_o ? lane_ld : '0;
    end

    // Sequencer FSM and command/batch registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            we_q        <= 1'b0;
            stride_q    <= '0;
            vl_q        <= '0;
            eew_q       <= '0;
            batch_q     <= '0;
            bbase_q     <= '0;
            st_buf_q    <= '0;
            rdata_q     <= '0;
            idle_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            idle_done_q <= 1'b0;
            err_q       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        we_q     <= cmd_we_i;
                        stride_q <= cmd_stride_i;
                        vl_q     <= cmd_vl_i;
                        eew_q    <= cmd_eew_i;
                        batch_q  <= '0;
                        bbase_q  <= cmd_base_i;
                        if (misaligned)
                            err_q <= 1'b1;
                        else if (cmd_vl_i == '0)
                            idle_done_q <= 1'b1;
                        else
                            state <= cmd_we_i ? S_FETCH : S_ISSUE;
                    end
                end
                S_FETCH: begin
                    if (st_data_valid_i) begin
                        st_buf_q <= st_data_i;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (vlsu.vlsu_ready_i)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (vlsu.vlsu_done_i) begin
                        rdata_q <= vlsu.vlsu_lane_rdata_i;
                        state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    batch_q <= batch_q + VL_W'(1);
                    bbase_q <= bbase_q + 64'(NUM_LANES) * stride_q;
                    if (last_batch)
                        state <= S_IDLE;
                    else
                        state <= we_q ? S_FETCH : S_ISSUE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef VLSU_PERF_CNT_EN
    // Batch and stall counters, free-running with natural 32-bit wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_batches_o <= '0;
            perf_stall_o   <= '0;
        end else begin
            if (state == S_RESP)
                perf_batches_o <= perf_batches_o + 32'd1;
            if ((state == S_WAIT) || ((state == S_ISSUE) && !vlsu.vlsu_ready_i))
                perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule
